// File: rtl/gpu_pixel_arbiter.sv
// gpu_pixel_arbiter
// Arbitrates three pixel sources (line, fill, arc) onto one output pixel FIFO.
// A source owns the FIFO for a whole primitive: ownership is granted in IDLE,
// held while the owner streams pixels, and released after the owner's last
// pixel is accepted or when the owner drops its request.
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   {line,fill,arc}_req_i          source holds a valid pixel
//   x_{line,fill,arc}_i            source pixel x (`WIDTH_BITS)
//   y_{line,fill,arc}_i            source pixel y (`HEIGHT_BITS)
//   {line,fill,arc}_last_i         current pixel ends the primitive
//   {line,fill,arc}_ack_o          pixel accepted this cycle
//   x_o, y_o                       FIFO head pixel, 0 when empty
//   pix_valid_o / pix_ready_i      FIFO head valid / downstream consumes head
//   owner_o                        0 line, 1 fill, 2 arc, 3 none
//   busy_o                         ownership held or FIFO non-empty
//
// Build option: define GPU_ARB_ROUND_ROBIN_EN for round-robin source selection
// (search starts after the last owner); otherwise fixed priority line>fill>arc.

`ifndef WIDTH_BITS
`define WIDTH_BITS 10
`endif
`ifndef HEIGHT_BITS
`define HEIGHT_BITS 9
`endif

module gpu_pixel_arbiter #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    line_req_i,
  input  logic                    fill_req_i,
  input  logic                    arc_req_i,
  input  logic [`WIDTH_BITS-1:0]  x_line_i,
  input  logic [`WIDTH_BITS-1:0]  x_fill_i,
  input  logic [`WIDTH_BITS-1:0]  x_arc_i,
  input  logic [`HEIGHT_BITS-1:0] y_line_i,
  input  logic [`HEIGHT_BITS-1:0] y_fill_i,
  input  logic [`HEIGHT_BITS-1:0] y_arc_i,
  input  logic                    line_last_i,
  input  logic                    fill_last_i,
  input  logic                    arc_last_i,
  output logic                    line_ack_o,
  output logic                    fill_ack_o,
  output logic                    arc_ack_o,
  output logic [`WIDTH_BITS-1:0]  x_o,
  output logic [`HEIGHT_BITS-1:0] y_o,
  output logic                    pix_valid_o,
  input  logic                    pix_ready_i,
  output logic [1:0]              owner_o,
  output logic                    busy_o
);

  localparam int XW    = `WIDTH_BITS;
  localparam int YW    = `HEIGHT_BITS;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {IDLE, OWNED} state_e;

  state_e             state_q, state_d;
  logic [1:0]         owner_q, owner_d;
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]   count_q;
  logic [XW-1:0]      x_mem_q [FIFO_DEPTH];
  logic [YW-1:0]      y_mem_q [FIFO_DEPTH];

  logic [2:0]         req;
  logic               own_req, own_last;
  logic [XW-1:0]      own_x;
  logic [YW-1:0]      own_y;
  logic               full, push, pop;
  logic [1:0]         grant;

  assign req = {arc_req_i, fill_req_i, line_req_i};

  // Route the current owner's request and pixel to the FIFO write side.
  always_comb begin
    own_req  = 1'b0;
    own_last = 1'b0;
    own_x    = '0;
    own_y    = '0;
    case (owner_q)
      2'd0: begin own_req = line_req_i; own_last = line_last_i; own_x = x_line_i; own_y = y_line_i; end
      2'd1: begin own_req = fill_req_i; own_last = fill_last_i; own_x = x_fill_i; own_y = y_fill_i; end
      2'd2: begin own_req = arc_req_i;  own_last = arc_last_i;  own_x = x_arc_i;  own_y = y_arc_i;  end
      default: ;
    endcase
  end

  // Fullness uses the registered count, so a same-cycle pop cannot free a slot
  // for this cycle's push. Reset suppresses acceptance in its own cycle.
  assign full = (count_q == CNT_W'(FIFO_DEPTH));
  assign push = (state_q == OWNED) && own_req && !full && !rst;
  assign pop  = (count_q != '0) && pix_ready_i;

`ifdef GPU_ARB_ROUND_ROBIN_EN
  logic [1:0] rr_last_q, rr_last_d;

  // Search order is last+1, last+2, last+3 (mod 3); iterating backwards lets
  // the nearest requester overwrite farther ones.
  function automatic logic [1:0] pick_rr(input logic [2:0] r, input logic [1:0] last);
    logic [1:0] win;
    win = 2'd0;
    for (int k = 3; k >= 1; k--) begin
      int idx;
      idx = (int'(last) + k) % 3;
      if (r[idx]) win = 2'(idx);
    end
    return win;
  endfunction

  assign grant = pick_rr(req, rr_last_q);
`else
  assign grant = req[0] ? 2'd0 : (req[1] ? 2'd1 : 2'd2);
`endif

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
`ifdef GPU_ARB_ROUND_ROBIN_EN
    rr_last_d = rr_last_q;
`endif
    case (state_q)
      IDLE: begin
        if (|req) begin
          state_d = OWNED;
          owner_d = grant;
`ifdef GPU_ARB_ROUND_ROBIN_EN
          rr_last_d = grant;
`endif
        end
      end
      OWNED: begin
        if ((push && own_last) || !own_req) begin
          state_d = IDLE;
          owner_d = 2'd3;
        end
      end
      default: begin
        state_d = IDLE;
        owner_d = 2'd3;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      owner_q  <= 2'd3;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
`ifdef GPU_ARB_ROUND_ROBIN_EN
      rr_last_q <= 2'd2;
`endif
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
`ifdef GPU_ARB_ROUND_ROBIN_EN
      rr_last_q <= rr_last_d;
`endif
      // Power-of-two depth: pointers wrap naturally at PTR_W bits.
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: ;
      endcase
    end
  end

  // Pixel storage carries no reset; the head is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      x_mem_q[wr_ptr_q] <= own_x;
      y_mem_q[wr_ptr_q] <= own_y;
    end
  end

  assign line_ack_o  = push && (owner_q == 2'd0);
  assign fill_ack_o  = push && (owner_q == 2'd1);
  assign arc_ack_o   = push && (owner_q == 2'd2);
  assign pix_valid_o = (count_q != '0);
  assign x_o         = pix_valid_o ? x_mem_q[rd_ptr_q] : '0;
  assign y_o         = pix_valid_o ? y_mem_q[rd_ptr_q] : '0;
  assign owner_o     = owner_q;
  assign busy_o      = (state_q == OWNED) || pix_valid_o;

endmodule

// File: tb/tb_gpu_pixel_arbiter.sv
`ifndef WIDTH_BITS
`define WIDTH_BITS 10
`endif
`ifndef HEIGHT_BITS
`define HEIGHT_BITS 9
`endif

module tb_gpu_pixel_arbiter;
  localparam int DEPTH = 4;
  localparam int XW = `WIDTH_BITS;
  localparam int YW = `HEIGHT_BITS;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [2:0] req = '0, lst = '0, ack;
  logic [XW-1:0] xs [3];
  logic [YW-1:0] ys [3];
  logic ready = 1'b0;
  logic [XW-1:0] x_o;
  logic [YW-1:0] y_o;
  logic pix_valid, busy;
  logic [1:0] owner;

  always #5 clk = ~clk;

  gpu_pixel_arbiter #(.FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .line_req_i(req[0]), .fill_req_i(req[1]), .arc_req_i(req[2]),
    .x_line_i(xs[0]), .x_fill_i(xs[1]), .x_arc_i(xs[2]),
    .y_line_i(ys[0]), .y_fill_i(ys[1]), .y_arc_i(ys[2]),
    .line_last_i(lst[0]), .fill_last_i(lst[1]), .arc_last_i(lst[2]),
    .line_ack_o(ack[0]), .fill_ack_o(ack[1]), .arc_ack_o(ack[2]),
    .x_o(x_o), .y_o(y_o), .pix_valid_o(pix_valid), .pix_ready_i(ready),
    .owner_o(owner), .busy_o(busy)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model: owner id + pixel queue ----------------
  typedef struct { int x; int y; } pix_t;
  pix_t mq[$];
  int   mown  = 3;
  int   mlast = 2;

  function automatic int choose(input logic [2:0] r);
`ifdef GPU_ARB_ROUND_ROBIN_EN
    for (int k = 1; k <= 3; k++)
      if (r[(mlast + k) % 3]) return (mlast + k) % 3;
    return 0;
`else
    if (r[0]) return 0;
    if (r[1]) return 1;
    return 2;
`endif
  endfunction

  function automatic logic [2:0] m_ack();
    logic [2:0] a;
    a = '0;
    if (!rst && mown != 3 && req[mown] && mq.size() < DEPTH) a[mown] = 1'b1;
    return a;
  endfunction

  task automatic mcheck();
    chk("m_ack", 32'(ack), 32'(m_ack()));
    chk("m_owner", 32'(owner), 32'(mown));
    chk("m_valid", 32'(pix_valid), 32'(mq.size() != 0));
    chk("m_x", 32'(x_o), mq.size() != 0 ? 32'(mq[0].x) : 32'd0);
    chk("m_y", 32'(y_o), mq.size() != 0 ? 32'(mq[0].y) : 32'd0);
    chk("m_busy", 32'(busy), 32'(mown != 3 || mq.size() != 0));
  endtask

  task automatic mupdate();
    logic [2:0] a;
    bit do_pop;
    if (rst) begin
      mq.delete();
      mown  = 3;
      mlast = 2;
      return;
    end
    a = m_ack();
    do_pop = (mq.size() != 0) && ready;
    if (mown == 3) begin
      if (req != 0) begin
        mown  = choose(req);
        mlast = mown;
      end
    end else begin
      if (a != 0) mq.push_back('{int'(xs[mown]), int'(ys[mown])});
      if ((a != 0 && lst[mown]) || !req[mown]) mown = 3;
    end
    if (do_pop) void'(mq.pop_front());
  endtask

  task automatic settle();
    #1;
    mcheck();
  endtask

  task automatic edge_step();
    @(posedge clk);
    mupdate();
    @(negedge clk);
  endtask

  task automatic cyc();
    settle();
    edge_step();
  endtask

  task automatic clear_inputs();
    req = '0; lst = '0; ready = 1'b0;
    for (int i = 0; i < 3; i++) begin xs[i] = '0; ys[i] = '0; end
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
  endtask

  // ---------------- directed vector table: 3-pixel line ----------------
  typedef struct {
    bit [2:0] req; bit [2:0] lst; bit ready; int x; int y;
    bit [2:0] eack; int eown; bit evalid; int ex; int ey; bit ebusy;
  } vec_t;
  vec_t tbl [7];

  int exp_grant [4];
  int p, nack, n, prev, bound;
  logic a0;

  initial begin
    clear_inputs();
    rst = 1'b1;
    edge_step();
    rst = 1'b0;

    tbl[0] = '{3'b000, 3'b000, 1'b1, 0, 0, 3'b000, 3, 1'b0, 0, 0, 1'b0};
    tbl[1] = '{3'b001, 3'b000, 1'b1, 5, 7, 3'b000, 3, 1'b0, 0, 0, 1'b0};
    tbl[2] = '{3'b001, 3'b000, 1'b1, 5, 7, 3'b001, 0, 1'b0, 0, 0, 1'b1};
    tbl[3] = '{3'b001, 3'b000, 1'b1, 6, 7, 3'b001, 0, 1'b1, 5, 7, 1'b1};
    tbl[4] = '{3'b001, 3'b001, 1'b1, 7, 7, 3'b001, 0, 1'b1, 6, 7, 1'b1};
    tbl[5] = '{3'b000, 3'b000, 1'b1, 0, 0, 3'b000, 3, 1'b1, 7, 7, 1'b1};
    tbl[6] = '{3'b000, 3'b000, 1'b1, 0, 0, 3'b000, 3, 1'b0, 0, 0, 1'b0};
    for (int i = 0; i < 7; i++) begin
      req = tbl[i].req; lst = tbl[i].lst; ready = tbl[i].ready;
      xs[0] = XW'(tbl[i].x); ys[0] = YW'(tbl[i].y);
      settle();
      chk($sformatf("tbl%0d_ack", i), 32'(ack), 32'(tbl[i].eack));
      chk($sformatf("tbl%0d_owner", i), 32'(owner), 32'(tbl[i].eown));
      chk($sformatf("tbl%0d_valid", i), 32'(pix_valid), 32'(tbl[i].evalid));
      chk($sformatf("tbl%0d_x", i), 32'(x_o), 32'(tbl[i].ex));
      chk($sformatf("tbl%0d_y", i), 32'(y_o), 32'(tbl[i].ey));
      chk($sformatf("tbl%0d_busy", i), 32'(busy), 32'(tbl[i].ebusy));
      edge_step();
    end

    // ---------------- grant order, all requesting, 1-pixel primitives ----------------
`ifdef GPU_ARB_ROUND_ROBIN_EN
    exp_grant = '{0, 1, 2, 0};
`else
    exp_grant = '{0, 0, 0, 0};
`endif
    do_reset();
    req = 3'b111; lst = 3'b111; ready = 1'b1;
    for (int i = 0; i < 3; i++) begin xs[i] = XW'(i + 1); ys[i] = YW'(i + 2); end
    n = 0; prev = 3;
    for (int c = 0; c < 30 && n < 4; c++) begin
      settle();
      if (owner != 2'd3 && prev == 3) begin
        chk($sformatf("grant%0d", n), 32'(owner), 32'(exp_grant[n]));
        n++;
      end
      prev = int'(owner);
      edge_step();
    end
    chk("grant_count", 32'(n), 32'd4);

    // ---------------- full FIFO backpressure, then pop-blocks-ack ----------------
    do_reset();
    req = 3'b001; p = 0; nack = 0;
    for (int c = 0; c < 8; c++) begin
      xs[0] = XW'(10 + p); ys[0] = YW'(20 + p); lst[0] = (p == 5);
      settle();
      a0 = ack[0];
      edge_step();
      if (a0) begin p++; nack++; end
    end
    chk("full_acks", 32'(nack), 32'd4);
    ready = 1'b1;
    xs[0] = XW'(10 + p); ys[0] = YW'(20 + p); lst[0] = (p == 5);
    settle();
    chk("full_pop_noack", 32'(ack[0]), 32'd0);
    chk("full_pop_valid", 32'(pix_valid), 32'd1);
    edge_step();
    settle();
    chk("after_pop_ack", 32'(ack[0]), 32'd1);
    a0 = ack[0];
    edge_step();
    if (a0) p++;
    bound = 0;
    while (p < 6 && bound < 20) begin
      xs[0] = XW'(10 + p); ys[0] = YW'(20 + p); lst[0] = (p == 5);
      settle();
      a0 = ack[0];
      edge_step();
      if (a0) p++;
      bound++;
    end
    chk("stream_done", 32'(p), 32'd6);
    req = '0; lst = '0;
    bound = 0;
    while (pix_valid && bound < 20) begin cyc(); bound++; end
    settle();
    chk("drain_busy", 32'(busy), 32'd0);
    edge_step();

    // ---------------- fill aborts after 2 pixels ----------------
    do_reset();
    req = 3'b010; p = 0;
    for (int c = 0; c < 3; c++) begin
      xs[1] = XW'(30 + p); ys[1] = YW'(40 + p);
      settle();
      a0 = ack[1];
      edge_step();
      if (a0) p++;
    end
    chk("abort_pixels", 32'(p), 32'd2);
    req = '0; ready = 1'b1;
    cyc();
    settle();
    chk("abort_owner", 32'(owner), 32'd3);
    chk("abort_valid", 32'(pix_valid), 32'd1);
    edge_step();
    bound = 0;
    while (pix_valid && bound < 10) begin cyc(); bound++; end
    settle();
    chk("abort_busy", 32'(busy), 32'd0);
    edge_step();

    // ---------------- reset mid-ownership ----------------
    do_reset();
    req = 3'b001;
    for (int c = 0; c < 4; c++) begin
      xs[0] = XW'(50 + c); ys[0] = YW'(60 + c);
      cyc();
    end
    rst = 1'b1;
    settle();
    chk("rst_cycle_ack", 32'(ack), 32'd0);
    edge_step();
    rst = 1'b0;
    settle();
    chk("rst_valid", 32'(pix_valid), 32'd0);
    chk("rst_owner", 32'(owner), 32'd3);
    chk("rst_x", 32'(x_o), 32'd0);
    chk("rst_y", 32'(y_o), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    edge_step();

    // ---------------- random traffic against the model ----------------
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 99) == 0);
      for (int i = 0; i < 3; i++) begin
        req[i] = ($urandom_range(0, 9) < 7);
        lst[i] = ($urandom_range(0, 3) == 0);
        xs[i]  = XW'($urandom);
        ys[i]  = YW'($urandom);
      end
      ready = ($urandom_range(0, 2) != 0);
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
